// File: rtl/tv80_alu16_seq.sv
// 16-bit ADD/ADC/SBC HL,rr sequencer driving the 8-bit tv80 ALU one byte at a time.
// Latency: start sampled at edge 0, LO pass in cycle 1, HI pass in cycle 2, done/result in cycle 3.
// No backpressure: start is only sampled in IDLE; requests while busy or with op=11 are dropped.
module tv80_alu16_seq #(
  parameter int Flag_C = 0,
  parameter int Flag_N = 1,
  parameter int Flag_P = 2,
  parameter int Flag_X = 3,
  parameter int Flag_H = 4,
  parameter int Flag_Y = 5,
  parameter int Flag_Z = 6,
  parameter int Flag_S = 7
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] opa,
  input  logic [15:0] opb,
  input  logic [7:0]  f_in,
  output logic [7:0]  alu_busa,
  output logic [7:0]  alu_busb,
  output logic [3:0]  alu_op,
  output logic [7:0]  alu_fin,
  output logic        alu_arith16,
  output logic        alu_z16,
  input  logic [7:0]  alu_q,
  input  logic [7:0]  alu_fout,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [7:0]  f_out
);

  // Only the defined flag positions are forwarded from the low pass to the high pass.
  localparam logic [7:0] FlagMask = 8'(8'h01 << Flag_C) | 8'(8'h01 << Flag_N) |
                                    8'(8'h01 << Flag_P) | 8'(8'h01 << Flag_X) |
                                    8'(8'h01 << Flag_H) | 8'(8'h01 << Flag_Y) |
                                    8'(8'h01 << Flag_Z) | 8'(8'h01 << Flag_S);

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSbc = 2'b10;
  localparam logic [1:0] OpRsv = 2'b11;
  localparam logic [3:0] AluNop = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2
  } state_t;

  state_t      state_q;
  logic [1:0]  op_q;
  logic [7:0]  a_hi_q;
  logic [7:0]  b_hi_q;
  logic [7:0]  lo_q;
  logic [7:0]  busa_q;
  logic [7:0]  busb_q;
  logic [7:0]  fin_q;
  logic [3:0]  aluop_q;
  logic        arith16_q;
  logic        z16_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] result_q;
  logic [7:0]  fout_q;

  logic [7:0]  lo_f_d;
  logic [7:0]  lo_fz_d;

  // Low-pass flags as seen by the high pass; ADC/SBC also carry the low-byte zero into Z.
  always_comb begin
    lo_f_d          = alu_fout & FlagMask;
    lo_fz_d         = lo_f_d;
    lo_fz_d[Flag_Z] = (alu_q == 8'h00);
  end

  // Sequencer FSM; every ALU-facing and result output is a register loaded on the transition.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      op_q      <= OpAdd;
      a_hi_q    <= 8'h00;
      b_hi_q    <= 8'h00;
      lo_q      <= 8'h00;
      busa_q    <= 8'h00;
      busb_q    <= 8'h00;
      fin_q     <= 8'h00;
      aluop_q   <= AluNop;
      arith16_q <= 1'b0;
      z16_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= 16'h0000;
      fout_q    <= 8'h00;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && (op != OpRsv)) begin
            op_q      <= op;
            a_hi_q    <= opa[15:8];
            b_hi_q    <= opb[15:8];
            busa_q    <= opa[7:0];
            busb_q    <= opb[7:0];
            fin_q     <= f_in;
            aluop_q   <= (op == OpSbc) ? 4'b0011 : {3'b000, op[0]};
            arith16_q <= 1'b1;
            z16_q     <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= S_LO;
          end
        end
        S_LO: begin
          lo_q    <= alu_q;
          busa_q  <= a_hi_q;
          busb_q  <= b_hi_q;
          aluop_q <= (op_q == OpSbc) ? 4'b0011 : 4'b0001;
          if (op_q == OpAdd) begin
            fin_q     <= lo_f_d;
            arith16_q <= 1'b1;
            z16_q     <= 1'b0;
          end else begin
            fin_q     <= lo_fz_d;
            arith16_q <= 1'b0;
            z16_q     <= 1'b1;
          end
          state_q <= S_HI;
        end
        S_HI: begin
          result_q  <= {alu_q, lo_q};
          fout_q    <= alu_fout;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          busa_q    <= 8'h00;
          busb_q    <= 8'h00;
          fin_q     <= 8'h00;
          aluop_q   <= AluNop;
          arith16_q <= 1'b0;
          z16_q     <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: begin
          busy_q    <= 1'b0;
          busa_q    <= 8'h00;
          busb_q    <= 8'h00;
          fin_q     <= 8'h00;
          aluop_q   <= AluNop;
          arith16_q <= 1'b0;
          z16_q     <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign alu_busa    = busa_q;
  assign alu_busb    = busb_q;
  assign alu_op      = aluop_q;
  assign alu_fin     = fin_q;
  assign alu_arith16 = arith16_q;
  assign alu_z16     = z16_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign f_out       = fout_q;

endmodule

// File: tb/tb_tv80_alu16_seq.sv
// Bench for tv80_alu16_seq: byte-level ALU stand-in on the ALU ports, word-level reference for results.
module tb_tv80_alu16_seq;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [15:0] opa;
  logic [15:0] opb;
  logic [7:0]  f_in;
  logic [7:0]  alu_busa;
  logic [7:0]  alu_busb;
  logic [3:0]  alu_op;
  logic [7:0]  alu_fin;
  logic        alu_arith16;
  logic        alu_z16;
  logic [7:0]  alu_q;
  logic [7:0]  alu_fout;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [7:0]  f_out;

  int checks = 0;
  int errors = 0;

  tv80_alu16_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .opa(opa), .opb(opb), .f_in(f_in),
    .alu_busa(alu_busa), .alu_busb(alu_busb), .alu_op(alu_op), .alu_fin(alu_fin),
    .alu_arith16(alu_arith16), .alu_z16(alu_z16), .alu_q(alu_q), .alu_fout(alu_fout),
    .busy(busy), .done(done), .result(result), .f_out(f_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit ALU stand-in: add/adc/sbc with tv80 flag rules, Arith16 and Z16 handling.
  function automatic logic [15:0] alu8(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] fi, input logic ar16, input logic z16);
    int cin, t, hn;
    logic [7:0] q, fo;
    logic c, h, v, n;
    if (o != 4'd0 && o != 4'd1 && o != 4'd3) return 16'h0000;
    cin = (o[0] && fi[0]) ? 1 : 0;
    if (o[1]) begin
      t  = int'(a) - int'(b) - cin;
      hn = int'(a[3:0]) - int'(b[3:0]) - cin;
      q  = t[7:0];
      c  = (t < 0);
      h  = (hn < 0);
      v  = (a[7] != b[7]) && (q[7] != a[7]);
      n  = 1'b1;
    end else begin
      t  = int'(a) + int'(b) + cin;
      hn = int'(a[3:0]) + int'(b[3:0]) + cin;
      q  = t[7:0];
      c  = (t > 255);
      h  = (hn > 15);
      v  = (a[7] == b[7]) && (q[7] != a[7]);
      n  = 1'b0;
    end
    fo[0] = c; fo[1] = n; fo[2] = v; fo[3] = q[3]; fo[4] = h; fo[5] = q[5];
    fo[6] = (q == 8'h00) ? (z16 ? fi[6] : 1'b1) : 1'b0;
    fo[7] = q[7];
    if (ar16) begin
      fo[7] = fi[7]; fo[6] = fi[6]; fo[2] = fi[2];
    end
    return {q, fo};
  endfunction

  assign {alu_q, alu_fout} = alu8(alu_op, alu_busa, alu_busb, alu_fin, alu_arith16, alu_z16);

  // Word-level reference for ADD/ADC/SBC HL,rr: {result, flags}.
  function automatic logic [23:0] ref16(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                                        input logic [7:0] f);
    int c, r, hn;
    logic [15:0] q;
    logic [7:0] fo;
    logic cy, h, v;
    c = (o != 2'b00 && f[0]) ? 1 : 0;
    if (o == 2'b10) begin
      r  = int'(a) - int'(b) - c;
      hn = int'(a[11:0]) - int'(b[11:0]) - c;
      q  = r[15:0];
      cy = (r < 0);
      h  = (hn < 0);
      v  = (a[15] != b[15]) && (q[15] != a[15]);
    end else begin
      r  = int'(a) + int'(b) + c;
      hn = int'(a[11:0]) + int'(b[11:0]) + c;
      q  = r[15:0];
      cy = (r > 65535);
      h  = (hn > 4095);
      v  = (a[15] == b[15]) && (q[15] != a[15]);
    end
    if (o == 2'b00) begin
      fo = f;
      fo[0] = cy; fo[1] = 1'b0; fo[3] = q[11]; fo[4] = h; fo[5] = q[13];
    end else begin
      fo = {q[15], (q == 16'h0000), q[13], h, q[11], v, (o == 2'b10), cy};
    end
    return {q, fo};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  // One operation with full cycle-by-cycle checks; optional start pulses while busy.
  task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                        input logic [7:0] f, input bit pulse);
    logic [23:0] e;
    logic [3:0] lo_op, hi_op;
    int extra;
    e = ref16(o, a, b, f);
    lo_op = (o == 2'b10) ? 4'b0011 : ((o == 2'b01) ? 4'b0001 : 4'b0000);
    hi_op = (o == 2'b10) ? 4'b0011 : 4'b0001;
    wait_idle();
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b; f_in = f;
    @(posedge clk); #1;
    start = 1'b0; opa = 16'($urandom); opb = 16'($urandom); f_in = 8'($urandom);
    op = 2'($urandom_range(0, 2));
    @(negedge clk);
    chk("lo_busy", 32'(busy), 32'd1);
    chk("lo_alu_op", 32'(alu_op), 32'(lo_op));
    chk("lo_busa", 32'(alu_busa), 32'(a[7:0]));
    chk("lo_busb", 32'(alu_busb), 32'(b[7:0]));
    chk("lo_arith16", 32'({alu_arith16, alu_z16}), 32'b10);
    if (o == 2'b10 && a == 16'h8000 && b == 16'h0001) chk("lo_borrow", 32'(alu_fout[0]), 32'd1);
    if (pulse) start = 1'b1;
    @(negedge clk);
    chk("hi_alu_op", 32'(alu_op), 32'(hi_op));
    chk("hi_busa", 32'(alu_busa), 32'(a[15:8]));
    chk("hi_z16", 32'({alu_arith16, alu_z16}), (o == 2'b00) ? 32'b10 : 32'b01);
    chk("hi_done", 32'(done), 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("done", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("result", 32'(result), 32'(e[23:8]));
    chk("f_out", 32'(f_out), 32'(e[7:0]));
    chk("idle_alu_op", 32'(alu_op), 32'hF);
    if (pulse) begin
      extra = 0;
      repeat (4) begin
        @(negedge clk);
        if (done || busy) extra++;
      end
      chk("extra_done", 32'(extra), 32'd0);
    end
  endtask

  initial begin
    logic [23:0] e1, e2;
    int cnt;
    reset_n = 1'b1; start = 1'b0; op = 2'b00; opa = 16'h0; opb = 16'h0; f_in = 8'h0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_f_out", 32'(f_out), 32'd0);
    chk("rst_alu", 32'({alu_op, alu_busa, alu_busb, alu_fin, alu_arith16, alu_z16}), 32'hF000000 << 2);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;

    // Directed cases with hand-derived expectations
    run_op(2'b00, 16'h0FFF, 16'h0001, 8'hC4, 1'b0);
    chk("add_dir", 32'({result, f_out}), 32'h1000D4);
    run_op(2'b01, 16'hFFFF, 16'h0000, 8'h01, 1'b0);
    chk("adc_dir", 32'({result, f_out}), 32'h000051);
    run_op(2'b10, 16'h8000, 16'h0001, 8'h00, 1'b0);
    chk("sbc_dir", 32'({result, f_out}), 32'h7FFF3E);
    run_op(2'b10, 16'h0100, 16'h0100, 8'h00, 1'b0);
    chk("sbc_zero", 32'({result, f_out}), 32'h000042);
    run_op(2'b01, 16'h0100, 16'h0000, 8'h00, 1'b0);
    chk("adc_lozero", 32'({result, f_out}), 32'h010000);

    // Reserved op is dropped
    @(negedge clk);
    start = 1'b1; op = 2'b11; opa = 16'h1234; opb = 16'h4321;
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy || done) cnt++;
    end
    start = 1'b0;
    chk("rsv_ignored", 32'(cnt), 32'd0);

    // Start pulses while busy
    run_op(2'b01, 16'h7FFF, 16'h0001, 8'h00, 1'b1);

    // Start held through the done cycle: back-to-back ops
    e1 = ref16(2'b00, 16'h1234, 16'h5678, 8'hFF);
    e2 = ref16(2'b10, 16'h0001, 16'h0002, 8'h01);
    @(negedge clk);
    start = 1'b1; op = 2'b00; opa = 16'h1234; opb = 16'h5678; f_in = 8'hFF;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("b2b_done1", 32'(done), 32'd1);
    chk("b2b_res1", 32'({result, f_out}), 32'(e1));
    op = 2'b10; opa = 16'h0001; opb = 16'h0002; f_in = 8'h01;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", 32'({busy, done}), 32'b10);
    @(negedge clk);
    chk("b2b_hi", 32'(done), 32'd0);
    @(negedge clk);
    chk("b2b_done2", 32'(done), 32'd1);
    chk("b2b_res2", 32'({result, f_out}), 32'(e2));

    // Reset asserted during the HI pass
    @(negedge clk);
    start = 1'b1; op = 2'b01; opa = 16'hABCD; opb = 16'h1111; f_in = 8'h01;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk); @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rsthi_busy", 32'({busy, done}), 32'd0);
    chk("rsthi_result", 32'({result, f_out}), 32'd0);
    chk("rsthi_alu_op", 32'(alu_op), 32'hF);
    @(negedge clk);
    reset_n = 1'b1;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    chk("rsthi_no_done", 32'(cnt), 32'd0);

    // Randomized operations against the word-level reference
    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom_range(0, 2)), 16'($urandom), 16'($urandom), 8'($urandom), bit'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
